// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/reset sequencer: controller states,
// termination causes and the default pass code.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_HALT    = 2'd1,
      CAUSE_LOOP    = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_t;

   localparam logic [31:0] DEFAULT_PASS_CODE = 32'd0;

endpackage

// File: rtl/pc_loop_detect.sv
// Flags a jump-to-self: pc unchanged for LOOP_CYCLES-1 consecutive samples.
// clear invalidates the delayed pc so the first sample after it never matches.
module pc_loop_detect
   import cpu_ctrl_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter int LOOP_CYCLES = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic [PC_W-1:0] pc,
   output logic            loop_hit
);

   localparam int              EQ_W    = $clog2(LOOP_CYCLES) + 1;
   localparam logic [EQ_W-1:0] HIT_CNT = EQ_W'(LOOP_CYCLES - 2);

   logic [PC_W-1:0] r_pc_prev;
   logic            r_prev_vld;
   logic [EQ_W-1:0] r_eq_cnt;
   logic            w_eq;

   assign w_eq     = r_prev_vld && (pc == r_pc_prev);
   // The current equal sample is the (LOOP_CYCLES-1)th when HIT_CNT are already counted.
   assign loop_hit = w_eq && (r_eq_cnt == HIT_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_prev  <= '0;
         r_prev_vld <= 1'b0;
         r_eq_cnt   <= '0;
      end else if (clear) begin
         r_pc_prev  <= '0;
         r_prev_vld <= 1'b0;
         r_eq_cnt   <= '0;
      end else begin
         r_pc_prev  <= pc;
         r_prev_vld <= 1'b1;
         if (!w_eq)
            r_eq_cnt <= '0;
         else if (r_eq_cnt != HIT_CNT)
            r_eq_cnt <= r_eq_cnt + EQ_W'(1);
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/reset sequencer around one core: holds core_rst, runs while counting
// cycles, and latches a verdict on halt, self-loop or timeout.
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int                RST_CYCLES  = 16,
   parameter int                CNT_W       = 32,
   parameter longint unsigned   MAX_CYCLES  = 100000,
   parameter int                PC_W        = 32,
   parameter int                LOOP_CYCLES = 8,
   parameter logic [31:0]       PASS_CODE   = DEFAULT_PASS_CODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             halt,
   input  logic [31:0]      halt_code,
   input  logic [PC_W-1:0]  pc,
   output logic             core_rst,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic [1:0]       cause,
   output logic [31:0]      result_code,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int               RC_W         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RST_LAST     = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MAX_CYCLES - 1);

   state_t           r_state;
   logic [RC_W-1:0]  r_rst_cnt;
   logic [CNT_W-1:0] r_cycle;
   cause_t           r_cause;
   logic             r_pass;
   logic [31:0]      r_result;
   logic             r_core_rst;
   logic             r_running;
   logic             r_done;

   state_t           w_state_nxt;
   logic [RC_W-1:0]  w_rst_cnt_nxt;
   logic [CNT_W-1:0] w_cycle_nxt;
   cause_t           w_cause_nxt;
   logic             w_pass_nxt;
   logic [31:0]      w_result_nxt;
   logic             w_clear_status;
   logic             w_loop_clear;
   logic             w_loop_hit;

   // Loop history only accumulates while the core is actually running.
   assign w_loop_clear = (r_state != ST_RUN);

   pc_loop_detect #(
      .PC_W        (PC_W),
      .LOOP_CYCLES (LOOP_CYCLES)
   ) u_loop (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_loop_clear),
      .pc       (pc),
      .loop_hit (w_loop_hit)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_rst_cnt_nxt  = r_rst_cnt;
      w_cycle_nxt    = r_cycle;
      w_cause_nxt    = r_cause;
      w_pass_nxt     = r_pass;
      w_result_nxt   = r_result;
      w_clear_status = 1'b0;

      if (abort) begin
         w_state_nxt    = ST_IDLE;
         w_clear_status = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt    = ST_RESET;
                  w_clear_status = 1'b1;
               end
            end
            ST_RESET: begin
               if (r_rst_cnt == RST_LAST) begin
                  w_state_nxt   = ST_RUN;
                  w_rst_cnt_nxt = '0;
               end else begin
                  w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
               end
            end
            ST_RUN: begin
               // The terminating cycle is still counted, so a timeout ends at MAX_CYCLES.
               w_cycle_nxt = r_cycle + CNT_W'(1);
               if (halt) begin
                  w_state_nxt  = ST_DONE;
                  w_cause_nxt  = CAUSE_HALT;
                  w_result_nxt = halt_code;
                  w_pass_nxt   = (halt_code == PASS_CODE);
               end else if (w_loop_hit) begin
                  w_state_nxt = ST_DONE;
                  w_cause_nxt = CAUSE_LOOP;
                  w_pass_nxt  = 1'b1;
               end else if (r_cycle == TIMEOUT_LAST) begin
                  w_state_nxt = ST_DONE;
                  w_cause_nxt = CAUSE_TIMEOUT;
                  w_pass_nxt  = 1'b0;
               end
            end
            ST_DONE: begin
               if (start) begin
                  w_state_nxt    = ST_RESET;
                  w_clear_status = 1'b1;
               end
            end
            default: begin
               w_state_nxt    = ST_IDLE;
               w_clear_status = 1'b1;
            end
         endcase
      end

      if (w_clear_status) begin
         w_rst_cnt_nxt = '0;
         w_cycle_nxt   = '0;
         w_cause_nxt   = CAUSE_NONE;
         w_pass_nxt    = 1'b0;
         w_result_nxt  = '0;
      end
   end

   // Status outputs follow the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_rst_cnt  <= '0;
         r_cycle    <= '0;
         r_cause    <= CAUSE_NONE;
         r_pass     <= 1'b0;
         r_result   <= '0;
         r_core_rst <= 1'b1;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rst_cnt  <= w_rst_cnt_nxt;
         r_cycle    <= w_cycle_nxt;
         r_cause    <= w_cause_nxt;
         r_pass     <= w_pass_nxt;
         r_result   <= w_result_nxt;
         r_core_rst <= (w_state_nxt != ST_RUN);
         r_running  <= (w_state_nxt == ST_RUN);
         r_done     <= (w_state_nxt == ST_DONE);
      end
   end

   assign core_rst    = r_core_rst;
   assign running     = r_running;
   assign done        = r_done;
   assign pass        = r_pass;
   assign cause       = r_cause;
   assign result_code = r_result;
   assign cycle_count = r_cycle;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with RST_CYCLES=4, LOOP_CYCLES=8, MAX_CYCLES=50.
module tb_cpu_run_controller;

   localparam int RST_CYCLES  = 4;
   localparam int CNT_W       = 32;
   localparam int PC_W        = 32;
   localparam int LOOP_CYCLES = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic             halt;
   logic [31:0]      halt_code;
   logic [PC_W-1:0]  pc;
   logic             core_rst;
   logic             running;
   logic             done;
   logic             pass;
   logic [1:0]       cause;
   logic [31:0]      result_code;
   logic [CNT_W-1:0] cycle_count;
   logic [5:0]       stat;

   int n_cmp;
   int n_bad;

   assign stat = {core_rst, running, done, pass, cause};

   cpu_run_controller #(
      .RST_CYCLES  (RST_CYCLES),
      .CNT_W       (CNT_W),
      .MAX_CYCLES  (50),
      .PC_W        (PC_W),
      .LOOP_CYCLES (LOOP_CYCLES),
      .PASS_CODE   (32'd0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .halt        (halt),
      .halt_code   (halt_code),
      .pc          (pc),
      .core_rst    (core_rst),
      .running     (running),
      .done        (done),
      .pass        (pass),
      .cause       (cause),
      .result_code (result_code),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start from IDLE/DONE and step through the reset window into RUN cycle 1.
   task automatic begin_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RST_CYCLES) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; halt = 1'b0; halt_code = '0; pc = '0;
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (stat !== 6'b100000) begin n_bad++; $display("FAIL reset_status: got %b want %b", stat, 6'b100000); end
      n_cmp++;
      if (cycle_count !== 32'd0 || result_code !== 32'd0) begin
         n_bad++; $display("FAIL reset_counts: got cycle %0d result %0h want 0 0", cycle_count, result_code);
      end
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      n_cmp++;
      if (stat !== 6'b100000) begin n_bad++; $display("FAIL idle_hold: got %b want %b", stat, 6'b100000); end
   endtask

   task automatic test_sequence();
      int bad;
      bad = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < RST_CYCLES; i++) begin
         if (core_rst !== 1'b1 || running !== 1'b0) bad++;
         if (i < RST_CYCLES - 1) tick();
      end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL reset_window: got %0d bad cycles want 0", bad); end
      tick();
      n_cmp++;
      if (stat !== 6'b010000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL run_entry: got %b cycle %0d want %b cycle 0", stat, cycle_count, 6'b010000);
      end
   endtask

   // Continues from RUN cycle 1; a stray start mid-run must be ignored.
   task automatic test_halt_pass();
      for (int i = 0; i < 19; i++) begin
         pc = 32'h1000 + 32'(4 * i);
         start = (i == 5);
         tick();
      end
      start = 1'b0;
      n_cmp++;
      if (running !== 1'b1 || cycle_count !== 32'd19) begin
         n_bad++; $display("FAIL start_in_run: got running %b cycle %0d want 1 19", running, cycle_count);
      end
      pc = 32'h2000; halt = 1'b1; halt_code = 32'd0;
      tick();
      halt = 1'b0;
      n_cmp++;
      if (stat !== 6'b101101) begin n_bad++; $display("FAIL halt_pass_status: got %b want %b", stat, 6'b101101); end
      n_cmp++;
      if (cycle_count !== 32'd20 || result_code !== 32'd0) begin
         n_bad++; $display("FAIL halt_pass_counts: got cycle %0d result %0h want 20 0", cycle_count, result_code);
      end
   endtask

   task automatic test_halt_fail_loop();
      begin_run();
      pc = 32'h100;
      repeat (7) tick();
      n_cmp++;
      if (running !== 1'b1 || cycle_count !== 32'd7) begin
         n_bad++; $display("FAIL pre_loop_run: got running %b cycle %0d want 1 7", running, cycle_count);
      end
      halt = 1'b1; halt_code = 32'd5;
      tick();
      halt = 1'b0; halt_code = '0;
      n_cmp++;
      if (stat !== 6'b101001) begin n_bad++; $display("FAIL halt_fail_status: got %b want %b", stat, 6'b101001); end
      n_cmp++;
      if (result_code !== 32'd5 || cycle_count !== 32'd8) begin
         n_bad++; $display("FAIL halt_fail_counts: got result %0h cycle %0d want 5 8", result_code, cycle_count);
      end
   endtask

   task automatic test_self_loop();
      begin_run();
      for (int i = 0; i < 10; i++) begin
         pc = 32'h58 + 32'(4 * i);
         tick();
      end
      pc = 32'h80;
      repeat (7) tick();
      n_cmp++;
      if (running !== 1'b1 || cycle_count !== 32'd17) begin
         n_bad++; $display("FAIL loop_early: got running %b cycle %0d want 1 17", running, cycle_count);
      end
      tick();
      n_cmp++;
      if (stat !== 6'b101110) begin n_bad++; $display("FAIL loop_status: got %b want %b", stat, 6'b101110); end
      n_cmp++;
      if (cycle_count !== 32'd18 || result_code !== 32'd0) begin
         n_bad++; $display("FAIL loop_counts: got cycle %0d result %0h want 18 0", cycle_count, result_code);
      end
   endtask

   task automatic test_timeout();
      begin_run();
      for (int i = 0; i < 49; i++) begin
         pc = 32'(4 * i);
         tick();
      end
      n_cmp++;
      if (running !== 1'b1 || cycle_count !== 32'd49) begin
         n_bad++; $display("FAIL timeout_early: got running %b cycle %0d want 1 49", running, cycle_count);
      end
      pc = 32'h1000;
      tick();
      n_cmp++;
      if (stat !== 6'b101011 || cycle_count !== 32'd50) begin
         n_bad++; $display("FAIL timeout_status: got %b cycle %0d want %b cycle 50", stat, cycle_count, 6'b101011);
      end
      halt = 1'b1; halt_code = 32'd0;
      for (int i = 0; i < 5; i++) begin
         pc = 32'h3000 + 32'(4 * i);
         tick();
      end
      halt = 1'b0;
      n_cmp++;
      if (stat !== 6'b101011 || cycle_count !== 32'd50 || result_code !== 32'd0) begin
         n_bad++; $display("FAIL done_hold: got %b cycle %0d result %0h want %b 50 0", stat, cycle_count, result_code, 6'b101011);
      end
   endtask

   task automatic test_restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (stat !== 6'b100000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL restart_clear: got %b cycle %0d want %b 0", stat, cycle_count, 6'b100000);
      end
      repeat (RST_CYCLES) tick();
      n_cmp++;
      if (stat !== 6'b010000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL restart_run: got %b cycle %0d want %b 0", stat, cycle_count, 6'b010000);
      end
   endtask

   // Continues from RUN cycle 1 left by test_restart.
   task automatic test_abort();
      for (int i = 0; i < 9; i++) begin
         pc = 32'h4000 + 32'(4 * i);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (stat !== 6'b100000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL abort_run: got %b cycle %0d want %b 0", stat, cycle_count, 6'b100000);
      end
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (RST_CYCLES + 2) tick();
      n_cmp++;
      if (stat !== 6'b100000) begin n_bad++; $display("FAIL abort_beats_start: got %b want %b", stat, 6'b100000); end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (RST_CYCLES + 2) tick();
      n_cmp++;
      if (stat !== 6'b100000) begin n_bad++; $display("FAIL abort_reset: got %b want %b", stat, 6'b100000); end
      begin_run();
      halt = 1'b1; halt_code = 32'd7;
      tick();
      halt = 1'b0; halt_code = '0;
      n_cmp++;
      if (stat !== 6'b101001 || result_code !== 32'd7) begin
         n_bad++; $display("FAIL halt_code7: got %b result %0h want %b 7", stat, result_code, 6'b101001);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (stat !== 6'b100000 || result_code !== 32'd0 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL abort_done: got %b result %0h cycle %0d want %b 0 0", stat, result_code, cycle_count, 6'b100000);
      end
   endtask

   task automatic test_async_reset();
      begin_run();
      for (int i = 0; i < 5; i++) begin
         pc = 32'h5000 + 32'(4 * i);
         tick();
      end
      n_cmp++;
      if (running !== 1'b1 || cycle_count !== 32'd5) begin
         n_bad++; $display("FAIL pre_async: got running %b cycle %0d want 1 5", running, cycle_count);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (stat !== 6'b100000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL async_reset: got %b cycle %0d want %b 0", stat, cycle_count, 6'b100000);
      end
      tick();
      rst = 1'b1;
      tick();
      begin_run();
      n_cmp++;
      if (stat !== 6'b010000 || cycle_count !== 32'd0) begin
         n_bad++; $display("FAIL run_after_async: got %b cycle %0d want %b 0", stat, cycle_count, 6'b010000);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_sequence();
      test_halt_pass();
      test_halt_fail_loop();
      test_self_loop();
      test_timeout();
      test_restart();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
